// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I LOAD/STORE/BRANCH fields into 32-bit words streamed with byte addresses.
// Define ENC_UJ_TYPE_EN to also encode LUI/AUIPC/JAL; otherwise those opcodes take the error path.
module instruction_encoder #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              err_sticky,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
`ifdef ENC_UJ_TYPE_EN
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
`endif
  localparam logic [31:0] NOP       = 32'h00000013;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, out_addr_q, out_addr_d;
  logic [31:0]       instr_q, instr_d, enc;
  logic              out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic              err_sticky_q, err_sticky_d, last_pending_q, last_pending_d;
  logic              enc_err, accept, handshake, load;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // start is only honoured outside RUN
  always_comb begin
    load    = start && state_q != RUN;
    state_d = load ? RUN : (state_q == RUN && handshake && last_pending_q) ? DONE : state_q;
  end

  always_comb begin
    in_ready  = state_q == RUN && !last_pending_q && (!out_valid_q || out_ready);
    done      = state_q == DONE;
    accept    = in_valid && in_ready;
    handshake = out_valid_q && out_ready;
  end

  always_comb begin
    enc     = NOP;
    enc_err = 1'b1;
    if (opcode == OP_LOAD) begin
      enc     = {imm[11:0], rs1, funct3, rd, opcode};
      enc_err = imm[31:11] != {21{imm[11]}};
    end else if (opcode == OP_STORE) begin
      enc     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      enc_err = imm[31:11] != {21{imm[11]}};
    end else if (opcode == OP_BRANCH) begin
      enc     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      enc_err = imm[31:12] != {20{imm[12]}} || imm[0];
    end
`ifdef ENC_UJ_TYPE_EN
    else if (opcode == OP_LUI || opcode == OP_AUIPC) begin
      enc     = {imm[31:12], rd, opcode};
      enc_err = imm[11:0] != 12'd0;
    end else if (opcode == OP_JAL) begin
      enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      enc_err = imm[31:20] != {12{imm[20]}} || imm[0];
    end
`endif
    if (enc_err) enc = NOP;
  end

  // output register holds while stalled; a new beat only lands when it is empty or draining
  always_comb begin
    addr_d         = load ? BASE_ADDR : accept ? addr_q + ADDR_W'(4) : addr_q;
    out_valid_d    = accept || (out_valid_q && !out_ready);
    instr_d        = accept ? enc : instr_q;
    out_addr_d     = accept ? addr_q : out_addr_q;
    out_err_d      = accept ? enc_err : out_err_q;
    err_sticky_d   = load ? 1'b0 : err_sticky_q || (accept && enc_err);
    last_pending_d = accept ? in_last : handshake ? 1'b0 : last_pending_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      out_valid_q    <= 1'b0;
      instr_q        <= '0;
      out_addr_q     <= '0;
      out_err_q      <= 1'b0;
      err_sticky_q   <= 1'b0;
      last_pending_q <= 1'b0;
    end else begin
      addr_q         <= addr_d;
      out_valid_q    <= out_valid_d;
      instr_q        <= instr_d;
      out_addr_q     <= out_addr_d;
      out_err_q      <= out_err_d;
      err_sticky_q   <= err_sticky_d;
      last_pending_q <= last_pending_d;
    end
  end

  always_comb begin
    out_valid  = out_valid_q;
    instr      = instr_q;
    out_addr   = out_addr_q;
    out_err    = out_err_q;
    err_sticky = err_sticky_q;
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: scoreboard bench for instruction_encoder built with ADDR_W=4 so address wrap is reachable.
module tb_instruction_encoder;
  localparam int AW = 4;
  typedef struct packed { logic [31:0] instr; logic [AW-1:0] addr; logic err; } word_t;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [6:0]    opcode = '0;
  logic [2:0]    funct3 = '0;
  logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]   imm = '0;
  logic          in_ready, out_valid, out_err, err_sticky, done;
  logic [31:0]   instr;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] exp_addr = '0;
  word_t         exp_q[$], obs_q[$];
  int            n_cmp = 0, n_bad = 0, stalls = 0;

  instruction_encoder #(.ADDR_W(AW), .BASE_ADDR(4'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .out_addr(out_addr),
    .out_err(out_err), .err_sticky(err_sticky), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid && out_ready) obs_q.push_back({instr, out_addr, out_err});

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang wanted finish");
    $fatal(1, "timeout");
  end

  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d, s1, s2,
                                        input logic [31:0] im);
    int s;
    logic bad;
    logic [31:0] w;
    s = $signed(im);
    bad = 1'b1;
    w = 32'h13;
    if (op == 7'b0000011) begin
      bad = s < -2048 || s > 2047;
      w = {im[11:0], s1, f3, d, op};
    end else if (op == 7'b0100011) begin
      bad = s < -2048 || s > 2047;
      w = {im[11:5], s2, s1, f3, im[4:0], op};
    end else if (op == 7'b1100011) begin
      bad = s < -4096 || s > 4094 || im[0];
      w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
    end
`ifdef ENC_UJ_TYPE_EN
    else if (op == 7'b0110111 || op == 7'b0010111) begin
      bad = im[11:0] != 12'd0;
      w = {im[31:12], d, op};
    end else if (op == 7'b1101111) begin
      bad = s < -1048576 || s > 1048574 || im[0];
      w = {im[20], im[10:1], im[11], im[19:12], d, op};
    end
`endif
    return bad ? {1'b1, 32'h13} : {1'b0, w};
  endfunction

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d, s1, s2,
                      input logic [31:0] im, input logic last, input logic [32:0] ex);
    bit ok;
    ok = 1'b0;
    opcode = op; funct3 = f3; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      if (!ok) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept: in_ready stayed %b for opcode %b, wanted 1", in_ready, op);
    end else begin
      exp_q.push_back({ex[31:0], exp_addr, ex[32]});
      exp_addr = exp_addr + AW'(4);
    end
  endtask

  task automatic send_m(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d, s1, s2,
                        input logic [31:0] im, input logic last);
    send(op, f3, d, s1, s2, im, last, model(op, f3, d, s1, s2, im));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); n_cmp++;
    if ({in_ready, out_valid, instr, out_addr, out_err, err_sticky, done} !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got rdy%b v%b %h @%0d e%b s%b d%b, wanted all zero",
               in_ready, out_valid, instr, out_addr, out_err, err_sticky, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle in_ready: got %b wanted 0", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    word_t e, o;
    do_start();
    out_ready = 1'b1;
    send(7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b0, {1'b0, 32'hFFC12283});
    send(7'b0100011, 3'b010, 5'd0, 5'd2, 5'd6, 32'd8, 1'b0, {1'b0, 32'h00612423});
    send(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0, {1'b0, 32'hFE208CE3});
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL basic word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL basic word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
    @(negedge clk); n_cmp++;
    if ({err_sticky, done} !== 2'b00) begin n_bad++; $display("FAIL basic flags: got sticky%b done%b, wanted 00", err_sticky, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    word_t e, o;
    send(7'b0000011, 3'b010, 5'd5, 5'd2, 5'd0, 32'd2048, 1'b0, {1'b1, 32'h00000013});
    send_m(7'b0000011, 3'b100, 5'd7, 5'd3, 5'd0, -32'sd2049, 1'b0);
    send_m(7'b0000011, 3'b000, 5'd31, 5'd30, 5'd0, -32'sd2048, 1'b0);
    send_m(7'b0100011, 3'b001, 5'd0, 5'd31, 5'd17, 32'd2047, 1'b0);
    send_m(7'b0100011, 3'b000, 5'd0, 5'd4, 5'd9, 32'd2048, 1'b0);
    send_m(7'b1100011, 3'b101, 5'd0, 5'd8, 5'd12, 32'd4094, 1'b0);
    send_m(7'b1100011, 3'b111, 5'd0, 5'd20, 5'd21, -32'sd4096, 1'b0);
    send_m(7'b1100011, 3'b001, 5'd0, 5'd3, 5'd4, 32'd4096, 1'b0);
    send_m(7'b0110011, 3'b000, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send_m(7'b0110111, 3'b000, 5'd10, 5'd0, 5'd0, 32'h12345000, 1'b0);
    send_m(7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'h00000800, 1'b0);
    send(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd5, 1'b1, {1'b1, 32'h00000013});
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL error word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL error word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
    @(negedge clk); n_cmp++;
    if ({err_sticky, done} !== 2'b11) begin n_bad++; $display("FAIL error sticky: got sticky%b done%b, wanted 11", err_sticky, done); end
    @(posedge clk); #1;
    do_start();
    @(negedge clk); n_cmp++;
    if ({err_sticky, done} !== 2'b00) begin n_bad++; $display("FAIL start clears: got sticky%b done%b, wanted 00", err_sticky, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    word_t e, o;
    logic [32:0] m;
    logic [AW-1:0] a;
    a = exp_addr;
    m = model(7'b0000011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16);
    out_ready = 1'b0;
    send(7'b0000011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, m);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); n_cmp++;
      if ({out_valid, in_ready, instr, out_addr} !== {1'b1, 1'b0, m[31:0], a}) begin
        n_bad++;
        $display("FAIL stall hold: got v%b rdy%b %h @%0d, wanted v1 rdy0 %h @%0d", out_valid, in_ready, instr, out_addr, m[31:0], a);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); n_cmp++;
    if (out_valid !== 1'b0 || obs_q.size() != 1) begin
      n_bad++;
      $display("FAIL stall release: got v%b with %0d words seen, wanted v0 with 1", out_valid, obs_q.size());
    end
    @(posedge clk); #1;
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL stall word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL stall word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
  endtask

  task automatic test_back_to_back();
    word_t e, o;
    stalls = 0;
    out_ready = 1'b1;
    send_m(7'b0000011, 3'b001, 5'd3, 5'd4, 5'd0, 32'd100, 1'b0);
    send_m(7'b0100011, 3'b000, 5'd0, 5'd5, 5'd6, -32'sd100, 1'b0);
    send_m(7'b1100011, 3'b100, 5'd0, 5'd7, 5'd8, 32'd64, 1'b0);
    send_m(7'b0000011, 3'b101, 5'd9, 5'd10, 5'd0, 32'h7FF, 1'b1);
    n_cmp++;
    if (stalls != 0) begin n_bad++; $display("FAIL back_to_back rate: got %0d stall cycles, wanted 0", stalls); end
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL b2b word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL b2b word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
  endtask

  task automatic test_last();
    word_t e, o;
    do_start();
    out_ready = 1'b1;
    send_m(7'b0000011, 3'b010, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    send_m(7'b0100011, 3'b010, 5'd0, 5'd3, 5'd4, 32'd12, 1'b0);
    send_m(7'b1100011, 3'b110, 5'd0, 5'd5, 5'd6, -32'sd2, 1'b0);
    send_m(7'b0000011, 3'b000, 5'd7, 5'd8, 5'd0, -32'sd1, 1'b0);
    send(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd5, 1'b1, {1'b1, 32'h00000013});
    @(negedge clk); n_cmp++;
    if (in_ready !== 1'b0) begin n_bad++; $display("FAIL last ready: got %b after last accept, wanted 0", in_ready); end
    @(negedge clk); n_cmp++;
    if ({done, in_ready, out_valid} !== 3'b100) begin n_bad++; $display("FAIL last done: got done%b rdy%b v%b, wanted 100", done, in_ready, out_valid); end
    @(posedge clk); #1;
    do_start();
    @(negedge clk); n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL restart done: got %b wanted 0", done); end
    @(posedge clk); #1;
    send_m(7'b0000011, 3'b011, 5'd2, 5'd3, 5'd0, 32'd40, 1'b0);
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL last word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL last word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
  endtask

  task automatic test_rst_mid();
    word_t e, o;
    out_ready = 1'b0;
    send_m(7'b0100011, 3'b000, 5'd0, 5'd1, 5'd1, 32'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); n_cmp++;
    if ({in_ready, out_valid, instr, out_addr, out_err, err_sticky, done} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid outputs: got rdy%b v%b %h @%0d e%b s%b d%b, wanted all zero",
               in_ready, out_valid, instr, out_addr, out_err, err_sticky, done);
    end
    void'(exp_q.pop_back());
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_mid drop: got %0d words after reset, wanted 0", obs_q.size()); end
    do_start();
    send_m(7'b0000011, 3'b010, 5'd6, 5'd7, 5'd0, 32'd20, 1'b0);
    for (int k = 0; k < 50 && obs_q.size() < exp_q.size(); k++) begin @(posedge clk); #1; end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs_q.size() == 0) begin n_bad++; $display("FAIL rst_mid word: got none, wanted %h @%0d", e.instr, e.addr); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_bad++; $display("FAIL rst_mid word: got %h @%0d e%b, wanted %h @%0d e%b", o.instr, o.addr, o.err, e.instr, e.addr, e.err); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_last();
    test_rst_mid();
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL stray words: got %0d unexpected, wanted 0", obs_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
